// File: rtl/data_mem_pipe_pkg.sv
// data_mem_pipe_pkg: shared types, latency bounds and byte-merge helper for data_mem_pipe
package data_mem_pipe_pkg;
  typedef enum logic {INIT, RUN} state_t;
  localparam int READ_LAT_MIN = 1;
  localparam int READ_LAT_MAX = 4;
  localparam int MAX_W = 512;
  localparam int MAX_B = MAX_W / 8;
  function automatic logic [MAX_W-1:0] byte_merge(input logic [MAX_W-1:0] old_w,
                                                  input logic [MAX_W-1:0] new_w,
                                                  input logic [MAX_B-1:0] be);
    logic [MAX_W-1:0] r;
    for (int k = 0; k < MAX_B; k++) r[8*k+:8] = be[k] ? new_w[8*k+:8] : old_w[8*k+:8];
    return r;
  endfunction
endpackage

// File: rtl/data_mem_pipe_rdpipe.sv
// data_mem_pipe_rdpipe: LAT-deep {valid, err, data} read pipeline with synchronous clear
// Ports: clk, rst (sync, active-high clear), in_valid/in_err/in_data (stage input),
//        out_valid/out_err/out_data (last stage; data holds its last valid value).
module data_mem_pipe_rdpipe #(
  parameter int DATA_W = 32,
  parameter int LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_err,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic              out_err,
  output logic [DATA_W-1:0] out_data
);
  logic              v [LAT];
  logic              e [LAT];
  logic [DATA_W-1:0] d [LAT];
  // data only advances behind a valid entry so the last stage holds the last result
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < LAT; k++) begin
        v[k] <= 1'b0;
        e[k] <= 1'b0;
        d[k] <= '0;
      end
    end else begin
      v[0] <= in_valid;
      e[0] <= in_valid & in_err;
      if (in_valid) d[0] <= in_data;
      for (int k = 1; k < LAT; k++) begin
        v[k] <= v[k-1];
        e[k] <= e[k-1];
        if (v[k-1]) d[k] <= d[k-1];
      end
    end
  end
  always_comb begin
    out_valid = v[LAT-1];
    out_err   = e[LAT-1];
    out_data  = d[LAT-1];
  end
endmodule

// File: rtl/data_mem_pipe.sv
// data_mem_pipe: byte-enabled word memory with write-first reads and READ_LAT-cycle read pipeline
// Ports: clk, rst (sync, active-high), in_ctrl_read, in_ctrl_write, in_addr (word address),
//        in_data, in_byte_en (per-byte write enable), out_data, out_valid, out_err
//        (read addressed >= DEPTH), out_ready (accepting requests; high only in RUN).
// Option: DATA_MEM_INIT_EN -> INIT sweeps mem[i]=i for every word before entering RUN;
//         otherwise INIT lasts a single cycle and memory is left untouched.
module data_mem_pipe
  import data_mem_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH = 65536,
  parameter int READ_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_ctrl_read,
  input  logic                in_ctrl_write,
  input  logic [31:0]         in_addr,
  input  logic [DATA_W-1:0]   in_data,
  input  logic [DATA_W/8-1:0] in_byte_en,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_valid,
  output logic                out_err,
  output logic                out_ready
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [32:0] DEPTH_X = 33'(DEPTH);
  if (READ_LAT < READ_LAT_MIN || READ_LAT > READ_LAT_MAX) begin : g_bad_lat
    $fatal(1, "data_mem_pipe: READ_LAT %0d outside %0d..%0d", READ_LAT, READ_LAT_MIN, READ_LAT_MAX);
  end
  if (DATA_W < 8 || DATA_W % 8 != 0 || DATA_W > MAX_W) begin : g_bad_w
    $fatal(1, "data_mem_pipe: DATA_W %0d must be a multiple of 8 in 8..%0d", DATA_W, MAX_W);
  end
  if (DEPTH < 1) begin : g_bad_depth
    $fatal(1, "data_mem_pipe: DEPTH %0d must be positive", DEPTH);
  end
  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              acc;
  logic              in_range;
  logic              wr_hit;
  logic              rd_en;
  logic [AW-1:0]     idx;
  logic [DATA_W-1:0] cur;
  logic [DATA_W-1:0] merged;
  logic [DATA_W-1:0] rd_word;
`ifdef DATA_MEM_INIT_EN
  logic [AW-1:0]     init_cnt;
`endif
  // a request coinciding with rst is dropped along with the rest of the pipeline
  always_comb begin
    acc      = out_ready & ~rst;
    in_range = {1'b0, in_addr} < DEPTH_X;
    idx      = in_addr[AW-1:0];
    cur      = mem[idx];
    merged   = DATA_W'(byte_merge(MAX_W'(cur), MAX_W'(in_data), MAX_B'(in_byte_en)));
    wr_hit   = acc & in_ctrl_write & in_range;
    rd_en    = acc & in_ctrl_read;
    rd_word  = !in_range ? '0 : wr_hit ? merged : cur;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= INIT;
      out_ready <= 1'b0;
`ifdef DATA_MEM_INIT_EN
      init_cnt  <= '0;
`endif
    end else if (state == INIT) begin
`ifdef DATA_MEM_INIT_EN
      init_cnt <= init_cnt + AW'(1);
      if (init_cnt == AW'(DEPTH - 1)) begin
        state     <= RUN;
        out_ready <= 1'b1;
      end
`else
      state     <= RUN;
      out_ready <= 1'b1;
`endif
    end
  end
  // INIT writes and accepted writes are exclusive: writes need out_ready, which is RUN-only
  always_ff @(posedge clk) begin
`ifdef DATA_MEM_INIT_EN
    if (!rst && state == INIT) mem[init_cnt] <= DATA_W'(init_cnt);
    else if (wr_hit) mem[idx] <= merged;
`else
    if (wr_hit) mem[idx] <= merged;
`endif
  end
  data_mem_pipe_rdpipe #(
    .DATA_W(DATA_W),
    .LAT   (READ_LAT)
  ) u_rdpipe (
    .clk      (clk),
    .rst      (rst),
    .in_valid (rd_en),
    .in_err   (~in_range),
    .in_data  (rd_word),
    .out_valid(out_valid),
    .out_err  (out_err),
    .out_data (out_data)
  );
endmodule

// File: tb/tb_data_mem_pipe.sv
// tb_data_mem_pipe: randomized and directed self-checking bench for data_mem_pipe against a queue-based memory model
module tb_data_mem_pipe;
  localparam int DW = 32;
  localparam int DEPTH = 16;
  localparam int LAT = 3;
`ifdef DATA_MEM_INIT_EN
  localparam int INIT_CYC = DEPTH;
`else
  localparam int INIT_CYC = 1;
`endif
  typedef struct {
    int          due;
    logic [DW-1:0] d;
    logic        e;
  } exp_t;
  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_ctrl_read = 1'b0;
  logic            in_ctrl_write = 1'b0;
  logic [31:0]     in_addr = '0;
  logic [DW-1:0]   in_data = '0;
  logic [DW/8-1:0] in_byte_en = '0;
  logic [DW-1:0]   out_data;
  logic            out_valid;
  logic            out_err;
  logic            out_ready;
  exp_t            q[$];
  logic [DW-1:0]   ref_mem [DEPTH];
  logic [DW-1:0]   last_data = '0;
  logic            exp_ready = 1'b0;
  int              init_cnt = 0;
  int              cyc = 0;
  int              vectors = 0;
  int              miscompares = 0;
  always #5 clk = ~clk;
  data_mem_pipe #(
    .DATA_W  (DW),
    .DEPTH   (DEPTH),
    .READ_LAT(LAT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_ctrl_read (in_ctrl_read),
    .in_ctrl_write(in_ctrl_write),
    .in_addr      (in_addr),
    .in_data      (in_data),
    .in_byte_en   (in_byte_en),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_err      (out_err),
    .out_ready    (out_ready)
  );
  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s at cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask
  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                          input logic [DW/8-1:0] be);
    logic [DW-1:0] mask = '0;
    for (int k = 0; k < DW/8; k++) if (be[k]) mask = mask | (DW'(8'hFF) << (8*k));
    return (old_w & ~mask) | (new_w & mask);
  endfunction
  // one clock cycle: drive inputs, advance the model, then check outputs after the edge
  task automatic step(input logic r, input logic rd, input logic wr, input logic [31:0] a,
                      input logic [DW-1:0] d, input logic [DW/8-1:0] be);
    exp_t t;
    rst = r;
    in_ctrl_read = rd;
    in_ctrl_write = wr;
    in_addr = a;
    in_data = d;
    in_byte_en = be;
    if (exp_ready && !r) begin
      if (wr && a < DEPTH) ref_mem[a[3:0]] = merge(ref_mem[a[3:0]], d, be);
      if (rd) begin
        t.due = cyc + LAT;
        t.e = a >= DEPTH;
        t.d = t.e ? '0 : ref_mem[a[3:0]];
        q.push_back(t);
      end
    end
    if (r) begin
      q.delete();
      exp_ready = 1'b0;
      init_cnt = 0;
    end else if (!exp_ready) begin
`ifdef DATA_MEM_INIT_EN
      ref_mem[init_cnt] = DW'(init_cnt);
`endif
      init_cnt++;
      exp_ready = init_cnt == INIT_CYC;
    end
    @(posedge clk);
    cyc++;
    #1;
    if (r) last_data = '0;
    if (q.size() > 0 && q[0].due == cyc) begin
      chk("out_valid", DW'(out_valid), DW'(1));
      chk("out_data", out_data, q[0].d);
      chk("out_err", DW'(out_err), DW'(q[0].e));
      last_data = q[0].d;
      void'(q.pop_front());
    end else begin
      chk("idle_valid", DW'(out_valid), DW'(0));
      chk("idle_err", DW'(out_err), DW'(0));
      chk("idle_data_hold", out_data, last_data);
    end
    chk("out_ready", DW'(out_ready), DW'(exp_ready));
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'd0, '0, '0);
  endtask
  task automatic wr_word(input logic [31:0] a, input logic [DW-1:0] d, input logic [DW/8-1:0] be);
    step(1'b0, 1'b0, 1'b1, a, d, be);
  endtask
  task automatic rd_word(input logic [31:0] a);
    step(1'b0, 1'b1, 1'b0, a, '0, '0);
  endtask
  task automatic reset_seq();
    repeat (3) step(1'b1, 1'b1, 1'b1, 32'd5, 32'hDEAD_BEEF, '1);
    for (int i = 0; i < INIT_CYC; i++) step(1'b0, 1'b1, 1'b1, 32'd0, 32'hDEAD_0000, '1);
  endtask
  initial begin
    reset_seq();
`ifdef DATA_MEM_INIT_EN
    rd_word(32'd5);
    rd_word(32'd15);
    idle(LAT);
`endif
    for (int i = 0; i < DEPTH; i++) wr_word(i, DW'(i), '1);
    wr_word(32'd3, 32'hAABB_CCDD, 4'b0101);
    rd_word(32'd3);
    idle(LAT);
    rd_word(32'd1);
    rd_word(32'd2);
    rd_word(32'd3);
    idle(LAT + 1);
    step(1'b0, 1'b1, 1'b1, 32'd7, 32'h1234_5678, '1);
    idle(LAT);
    wr_word(32'd20, 32'hFFFF_FFFF, '1);
    rd_word(32'd20);
    rd_word(32'd4);
    idle(LAT);
    wr_word(32'd9, 32'hCAFE_F00D, '0);
    rd_word(32'd9);
    wr_word(32'd10, 32'h0102_0304, 4'b1000);
    rd_word(32'd10);
    rd_word(32'hFFFF_FFFF);
    idle(LAT);
    rd_word(32'd2);
    rd_word(32'd6);
    step(1'b1, 1'b0, 1'b0, 32'd0, '0, '0);
    step(1'b1, 1'b0, 1'b0, 32'd0, '0, '0);
    for (int i = 0; i < INIT_CYC; i++) step(1'b0, 1'b1, 1'b0, 32'd1, '0, '0);
    rd_word(32'd6);
    rd_word(32'd11);
    idle(LAT);
    for (int i = 0; i < 400; i++)
      step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 32'($urandom_range(0, DEPTH + 3)),
           DW'($urandom), 4'($urandom_range(0, 15)));
    idle(LAT + 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
